// File: rtl/vanilla_instr_encoder.sv
// Instruction encoder: compact op descriptors in, legal RV32I words out.
// One command per valid/ready accept; words leave on a valid/yumi port.
module vanilla_instr_encoder #(
  parameter int cnt_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [3:0]             op_i,
  input  logic [4:0]             rd_i,
  input  logic [4:0]             rs1_i,
  input  logic [4:0]             rs2_i,
  input  logic [31:0]            imm_i,
  output logic                   v_o,
  output logic [31:0]            instr_o,
  input  logic                   yumi_i,
  output logic [cnt_width_p-1:0] instr_count_o,
  output logic                   error_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LAST  = 2'd1;
  localparam logic [1:0] FIRST = 2'd2;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LI    = 4'd1;
  localparam logic [3:0] OP_ADDI  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_LW    = 4'd4;
  localparam logic [3:0] OP_SW    = 4'd5;
  localparam logic [3:0] OP_JAL   = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_FENCE = 4'd8;

  logic [1:0]             r_state;
  logic [31:0]            r_instr;
  logic [31:0]            r_pend;
  logic [cnt_width_p-1:0] r_cnt;
  logic                   r_err;

  logic        w_accept;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic        w_lo_nz;
  logic [19:0] w_hi20;
  logic [31:0] w_word;
  logic [31:0] w_pend;
  logic        w_two;
  logic        w_bad;

  // Sign-extension check: all bits above the field's sign bit match it
  assign w_fit12 = (imm_i[31:11] == '0) | (imm_i[31:11] == '1);
  assign w_fit13 = (imm_i[31:12] == '0) | (imm_i[31:12] == '1);
  assign w_fit21 = (imm_i[31:20] == '0) | (imm_i[31:20] == '1);
  assign w_lo_nz = (imm_i[11:0] != 12'd0);
  // Round up the upper part because the trailing ADDI sign-extends
  assign w_hi20  = imm_i[31:12] + {19'd0, imm_i[11]};

  always_comb begin
    w_word = 32'h0000_0013;
    w_pend = 32'h0000_0013;
    w_two  = 1'b0;
    w_bad  = 1'b0;
    unique case (op_i)
      OP_NOP: w_word = 32'h0000_0013;
      OP_LI: begin
        if (w_fit12) begin
          w_word = {imm_i[11:0], 5'd0, 3'b000, rd_i, 7'b0010011};
        end else begin
          w_word = {w_hi20, rd_i, 7'b0110111};
          w_pend = {imm_i[11:0], rd_i, 3'b000, rd_i, 7'b0010011};
          w_two  = w_lo_nz;
        end
      end
      OP_ADDI: begin
        w_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b0010011};
        w_bad  = !w_fit12;
      end
      OP_ADD: w_word = {7'd0, rs2_i, rs1_i, 3'b000, rd_i, 7'b0110011};
      OP_LW: begin
        w_word = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
        w_bad  = !w_fit12;
      end
      OP_SW: begin
        w_word = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0],
                  7'b0100011};
        w_bad  = !w_fit12;
      end
      OP_JAL: begin
        w_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                  rd_i, 7'b1101111};
        w_bad  = !w_fit21 | imm_i[0];
      end
      OP_BEQ: begin
        w_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                  imm_i[4:1], imm_i[11], 7'b1100011};
        w_bad  = !w_fit13 | imm_i[0];
      end
      OP_FENCE: w_word = 32'h0FF0_000F;
      default: w_bad = 1'b1;
    endcase
  end

  assign v_o     = (r_state == LAST) | (r_state == FIRST);
  assign ready_o = reset_n_i &
                   ((r_state == IDLE) | ((r_state == LAST) & yumi_i));
  assign w_accept = v_i & ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_bad) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_instr <= w_word;
          r_pend  <= w_pend;
          r_state <= w_two ? FIRST : LAST;
        end
      end else if (yumi_i) begin
        if (r_state == FIRST) begin
          r_instr <= r_pend;
          r_state <= LAST;
        end else if (r_state == LAST) begin
          r_state <= IDLE;
        end
      end
      if (v_o & yumi_i) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign instr_o       = r_instr;
  assign instr_count_o = r_cnt;
  assign error_o       = r_err;

endmodule

// File: tb/tb_vanilla_instr_encoder.sv
// Directed bench for vanilla_instr_encoder with a 4-bit counter.
// Hand-computed encodings; per-scenario tasks with inline checks.
module tb_vanilla_instr_encoder;

  logic        clk_i;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  logic [3:0]  op_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        v_o;
  logic [31:0] instr_o;
  logic        yumi_i;
  logic [3:0]  instr_count_o;
  logic        error_o;

  int total;
  int bad;
  int exp_cnt;

  vanilla_instr_encoder #(.cnt_width_p(4)) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .op_i(op_i),
    .rd_i(rd_i),
    .rs1_i(rs1_i),
    .rs2_i(rs2_i),
    .imm_i(imm_i),
    .v_o(v_o),
    .instr_o(instr_o),
    .yumi_i(yumi_i),
    .instr_count_o(instr_count_o),
    .error_o(error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm);
    v_i   = 1'b1;
    op_i  = op;
    rd_i  = rd;
    rs1_i = rs1;
    rs2_i = rs2;
    imm_i = imm;
  endtask

  task automatic idle_in();
    v_i = 1'b0; op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    imm_i = '0; yumi_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
    #1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cmd(4'd1, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    tick();
    v_i = 1'b0;
    #1;
    total++;
    if (v_o !== 1'b1) begin
      bad++; $display("FAIL rst_pre v_o got=%b exp=1", v_o);
    end
    reset_n_i = 1'b0;
    #1;
    total++;
    if ({v_o, ready_o, error_o} !== 3'b000 || instr_o !== 32'h0
        || instr_count_o !== 4'd0) begin
      bad++;
      $display("FAIL rst_held v=%b rdy=%b err=%b instr=%h cnt=%0d exp all 0",
               v_o, ready_o, error_o, instr_o, instr_count_o);
    end
    tick();
    reset_n_i = 1'b1;
    tick();
    total++;
    if ({v_o, ready_o, error_o} !== 3'b010 || instr_count_o !== 4'd0) begin
      bad++;
      $display("FAIL rst_rel v=%b rdy=%b err=%b cnt=%0d exp v0 rdy1 err0 c0",
               v_o, ready_o, error_o, instr_count_o);
    end
    exp_cnt = 0;
  endtask

  task automatic test_li(input string nm, input logic [4:0] rd,
                         input logic [31:0] imm, input logic two,
                         input logic [31:0] w0, input logic [31:0] w1);
    cmd(4'd1, rd, 5'd0, 5'd0, imm);
    yumi_i = 1'b0;
    tick();
    v_i = 1'b0;
    yumi_i = 1'b1;
    #1;
    total++;
    if (v_o !== 1'b1 || instr_o !== w0) begin
      bad++;
      $display("FAIL %s w0 v=%b got=%h exp=%h", nm, v_o, instr_o, w0);
    end
    if (two) begin
      total++;
      if (ready_o !== 1'b0) begin
        bad++; $display("FAIL %s first_ready got=%b exp=0", nm, ready_o);
      end
      tick();
      exp_cnt++;
      total++;
      if (v_o !== 1'b1 || instr_o !== w1) begin
        bad++;
        $display("FAIL %s w1 v=%b got=%h exp=%h", nm, v_o, instr_o, w1);
      end
    end
    tick();
    exp_cnt++;
    yumi_i = 1'b0;
    #1;
    total++;
    if (v_o !== 1'b0 || instr_count_o !== 4'(exp_cnt)) begin
      bad++;
      $display("FAIL %s end v=%b cnt=%0d exp v0 cnt=%0d", nm, v_o,
               instr_count_o, exp_cnt % 16);
    end
  endtask

  task automatic test_backpressure();
    cmd(4'd5, 5'd0, 5'd2, 5'd6, 32'd8);
    tick();
    cmd(4'd3, 5'd7, 5'd1, 5'd2, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (v_o !== 1'b1 || ready_o !== 1'b0 || instr_o !== 32'h0061_2423) begin
        bad++;
        $display("FAIL bp_hold%0d v=%b rdy=%b got=%h exp=00612423", i,
                 v_o, ready_o, instr_o);
      end
      tick();
    end
    yumi_i = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b1) begin
      bad++; $display("FAIL bp_ready got=%b exp=1", ready_o);
    end
    tick();
    exp_cnt++;
    v_i = 1'b0;
    #1;
    total++;
    if (v_o !== 1'b1 || instr_o !== 32'h0020_83B3) begin
      bad++;
      $display("FAIL bp_next v=%b got=%h exp=002083b3", v_o, instr_o);
    end
    tick();
    exp_cnt++;
    yumi_i = 1'b0;
    #1;
    total++;
    if (v_o !== 1'b0 || instr_count_o !== 4'(exp_cnt)) begin
      bad++;
      $display("FAIL bp_end v=%b cnt=%0d exp=%0d", v_o, instr_count_o,
               exp_cnt % 16);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [6];
    logic [4:0]  rds [6];
    logic [4:0]  r1s [6];
    logic [4:0]  r2s [6];
    logic [31:0] ims [6];
    logic [31:0] exp [6];
    ops = '{4'd4, 4'd6, 4'd7, 4'd2, 4'd8, 4'd0};
    rds = '{5'd4, 5'd1, 5'd0, 5'd10, 5'd0, 5'd0};
    r1s = '{5'd3, 5'd0, 5'd1, 5'd11, 5'd0, 5'd0};
    r2s = '{5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0};
    ims = '{32'hFFFF_FFFC, 32'h0000_0800, 32'hFFFF_FFF8,
            32'hFFFF_FFFF, 32'h0, 32'h0};
    exp = '{32'hFFC1_A203, 32'h0010_00EF, 32'hFE20_8CE3,
            32'hFFF5_8513, 32'h0FF0_000F, 32'h0000_0013};
    cmd(ops[0], rds[0], r1s[0], r2s[0], ims[0]);
    yumi_i = 1'b0;
    tick();
    for (int i = 1; i < 6; i++) begin
      cmd(ops[i], rds[i], r1s[i], r2s[i], ims[i]);
      yumi_i = 1'b1;
      #1;
      total++;
      if (v_o !== 1'b1 || ready_o !== 1'b1 || instr_o !== exp[i-1]) begin
        bad++;
        $display("FAIL b2b%0d v=%b rdy=%b got=%h exp=%h", i - 1, v_o,
                 ready_o, instr_o, exp[i-1]);
      end
      tick();
      exp_cnt++;
    end
    v_i = 1'b0;
    #1;
    total++;
    if (v_o !== 1'b1 || instr_o !== exp[5]) begin
      bad++;
      $display("FAIL b2b5 v=%b got=%h exp=%h", v_o, instr_o, exp[5]);
    end
    tick();
    exp_cnt++;
    yumi_i = 1'b0;
    #1;
    total++;
    if (v_o !== 1'b0 || instr_count_o !== 4'(exp_cnt)) begin
      bad++;
      $display("FAIL b2b_end v=%b cnt=%0d exp=%0d", v_o, instr_count_o,
               exp_cnt % 16);
    end
  endtask

  task automatic test_error(input string nm, input logic [3:0] op,
                            input logic [31:0] imm);
    do_reset();
    total++;
    if (error_o !== 1'b0) begin
      bad++; $display("FAIL %s pre err got=%b exp=0", nm, error_o);
    end
    cmd(op, 5'd1, 5'd2, 5'd3, imm);
    tick();
    v_i = 1'b0;
    #1;
    total++;
    if (error_o !== 1'b1 || v_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s err=%b v=%b rdy=%b exp err1 v0 rdy1", nm, error_o,
               v_o, ready_o);
    end
    tick();
    tick();
    total++;
    if (error_o !== 1'b1) begin
      bad++; $display("FAIL %s sticky got=%b exp=1", nm, error_o);
    end
    cmd(4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    v_i = 1'b0;
    yumi_i = 1'b1;
    #1;
    total++;
    if (v_o !== 1'b1 || instr_o !== 32'h0000_0013 || error_o !== 1'b1) begin
      bad++;
      $display("FAIL %s nop v=%b got=%h err=%b exp=00000013", nm, v_o,
               instr_o, error_o);
    end
    tick();
    exp_cnt++;
    yumi_i = 1'b0;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    cmd(4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    yumi_i = 1'b1;
    for (int i = 1; i < 17; i++) begin
      tick();
      exp_cnt++;
    end
    v_i = 1'b0;
    tick();
    exp_cnt++;
    yumi_i = 1'b0;
    #1;
    total++;
    if (instr_count_o !== 4'd1 || v_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap cnt=%0d v=%b exp cnt=1 v=0", instr_count_o, v_o);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 0;
    reset_n_i = 1'b1;
    idle_in();
    test_reset();
    test_li("li_big", 5'd5, 32'h1234_5678, 1'b1, 32'h1234_52B7,
            32'h6782_8293);
    test_li("li_800", 5'd1, 32'h0000_0800, 1'b1, 32'h0000_10B7,
            32'h8000_8093);
    test_li("li_m1", 5'd3, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0193, 32'h0);
    test_li("li_lui", 5'd2, 32'h0001_0000, 1'b0, 32'h0001_0137, 32'h0);
    test_backpressure();
    test_back_to_back();
    test_error("err_op12", 4'd12, 32'd0);
    test_error("err_beq3", 4'd7, 32'd3);
    test_error("err_addi", 4'd2, 32'd2048);
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
